led_animator: RTL and testbench
===============================

# led_animator

Parametrised LED-bar animation engine for the Pong score display, driven by `BALL_CLOCK`. It converts single-cycle goal and win events into repeated sweep, converge and fill patterns on an N-bit LED bar. Compared with the fixed 8-LED animation it adds:

- width, timing and repeat-count parameters;
- win-over-goal priority with preemption;
- a one-deep pending-goal slot;
- `busy`, `done` and `anim_id` status outputs for the game controller.

## Interface
Parameters:
- `LED_WIDTH`, default 8: LED bar width; must be even and ≥ 4.
- `STEP_CYCLES`, default 1: clock cycles each frame is held; ≥ 1.
- `LEAD_CYCLES`, default 3: dark cycles before the first frame; ≥ 0.
- `REPEATS`, default 3: pattern repetitions per animation; ≥ 1.

Ports:
- `BALL_CLOCK` in 1: sole clock; all logic is on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `goal_player_1` in 1: goal event pulse; requests animation GOAL1.
- `goal_player_2` in 1: goal event pulse; requests animation GOAL2.
- `win_player_1` in 1: win event pulse; requests animation WIN1.
- `win_player_2` in 1: win event pulse; requests animation WIN2.
- `led` out `LED_WIDTH`: LED pattern.
- `busy` out 1: an animation is in progress (lead-in or frames).
- `done` out 1: one-cycle pulse when an animation completes normally.
- `anim_id` out 2: animation in progress, 0=GOAL1, 1=GOAL2, 2=WIN1, 3=WIN2; holds its last value when idle.

## Operation
- Every cycle an event input is high counts as one event. Sources pulse for one cycle.
- States:
  - IDLE: `led`=0, `busy`=0.
  - LEAD: `led`=0 for `LEAD_CYCLES` cycles. Skipped when `LEAD_CYCLES` is 0.
  - RUN: frames step by frame index; each frame is held `STEP_CYCLES` cycles.
- One repetition is the pattern frames followed by one dark frame. After `REPEATS` repetitions the block completes. W = `LED_WIDTH`.
- Patterns:
  - GOAL1: W frames; frame k lights only bit W-1-k (sweeps MSB→LSB).
  - GOAL2: W frames; frame k lights only bit k (sweeps LSB→MSB).
  - WIN1: converge frames k=0..W/2-1 light bits k and W-1-k. Then fill frames j=1..W/2-1 light bits W/2-1 up to W/2+j.
  - WIN2: same converge frames. Then fill frames j=1..W/2-1 light bits W/2-1-j up to W/2.
- Event start priority: `win_player_1` > `win_player_2` > pending goal > `goal_player_1` > `goal_player_2`.
- From IDLE, the winning request starts at that edge. If both goals are present, `goal_player_1` starts and `goal_player_2` goes to pending.
- While running GOAL1 or GOAL2:
  - A win event aborts the current animation at that edge and restarts in LEAD with the win's `anim_id`.
  - The aborted animation does not pulse `done`.
  - The pending slot is cleared.
  - A goal event is written to the pending slot, overwriting any older pending goal.
- While running WIN1 or WIN2: all goal events are dropped; a repeated win event is ignored.
- Completion edge (end of the final dark frame):
  - `done` asserts for one cycle.
  - The start rules are evaluated as in IDLE, with pending included.
  - If something starts, `busy` stays 1 with no gap; otherwise the block goes to IDLE.
- Frame and cycle counters are sized with `$clog2`; no counter wraps within a legal configuration.

## Timing
- Reset values: `led`=0, `busy`=0, `done`=0, `anim_id`=0, pending cleared, state IDLE. Reset takes effect immediately, including mid-animation.
- Start latency:
  - An event sampled at edge t gives `busy`=1 and `anim_id` valid after edge t.
  - The first frame appears after edge t+`LEAD_CYCLES`.
- Busy duration = `LEAD_CYCLES` + `REPEATS`·(frames+1)·`STEP_CYCLES`, where frames = W for goals and W-1 for wins.
  - Defaults: goal 30 cycles, win 27 cycles.
- `done` is high for exactly one cycle, starting at the completion edge, i.e. the same edge at which `busy` falls (or a chained animation starts).
- Preemption takes effect at the edge sampling the win: `led` is 0 from the next cycle.

## Test plan
- Defaults, `goal_player_1` pulse → `led` 00 ×3 cycles, then 80,40,20,10,08,04,02,01,00 repeated 3 times; `busy` high 30 cycles; `done` one pulse; `anim_id`=0.
- Defaults, `win_player_2` pulse → 00 ×3, then 81,42,24,18,1C,1E,1F,00 ×3; `busy` high 27 cycles; `anim_id`=3.
- `goal_player_2` pulse at cycle 10 of GOAL1 → GOAL1 finishes unchanged; `done` pulses; GOAL2 lead-in starts on the same edge with `busy` held high; `anim_id`=1.
- `win_player_1` pulse at cycle 8 of GOAL2, with a goal already pending → `led`=00 next cycle; `anim_id`=2; no `done` for GOAL2; WIN1 runs in full; pending goal never plays.
- `RESET` asserted mid-RUN → `led`=0, `busy`=0, `done`=0 immediately. After release, a `goal_player_1` pulse restarts cleanly from lead-in.
- `LED_WIDTH`=6, `STEP_CYCLES`=2, `LEAD_CYCLES`=0, `REPEATS`=1, `win_player_1` → 21,12,0C,1C,3C,00, each frame held 2 cycles; `busy` high 12 cycles.

Source files
------------

// File: rtl/led_animator.sv
// LED-bar animation engine for the Pong score display: turns goal/win pulses into
// repeated sweep, converge and fill patterns with win preemption and a pending goal.
module led_animator #(
   parameter int LED_WIDTH   = 8,
   parameter int STEP_CYCLES = 1,
   parameter int LEAD_CYCLES = 3,
   parameter int REPEATS     = 3
) (
   input  logic                 BALL_CLOCK,
   input  logic                 RESET,
   input  logic                 goal_player_1,
   input  logic                 goal_player_2,
   input  logic                 win_player_1,
   input  logic                 win_player_2,
   output logic [LED_WIDTH-1:0] led,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           anim_id
);

   localparam int FW = $clog2(LED_WIDTH + 1);
   localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int LW = (LEAD_CYCLES > 1) ? $clog2(LEAD_CYCLES) : 1;
   localparam int RW = (REPEATS > 1) ? $clog2(REPEATS) : 1;

   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
   localparam logic [LW-1:0] LEAD_LAST = LW'((LEAD_CYCLES > 0) ? LEAD_CYCLES - 1 : 0);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEATS - 1);
   localparam logic [FW-1:0] GOAL_LAST = FW'(LED_WIDTH);
   localparam logic [FW-1:0] WIN_LAST  = FW'(LED_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, LEAD, RUN} state_t;

   state_t          state, nxt_state;
   logic [LW-1:0]   lead_cnt, nxt_lead;
   logic [SW-1:0]   step_cnt, nxt_step;
   logic [FW-1:0]   frame_idx, nxt_frame, frame_last;
   logic [RW-1:0]   rep_cnt, nxt_rep;
   logic            pend_vld, nxt_pend_vld;
   logic            pend_id, nxt_pend_id;
   logic [1:0]      nxt_id;
   logic            nxt_done;
   logic            launch;
   logic            start_vld, keep_vld, keep_id;
   logic [1:0]      start_id;

   // Frame index to LED pattern; the last index of each repetition is the dark frame.
   function automatic logic [LED_WIDTH-1:0] pattern(input logic [1:0] id,
                                                    input logic [FW-1:0] frame);
      logic [LED_WIDTH-1:0] p;
      int f, j, lo, hi;
      logic conv;
      f    = int'(frame);
      lo   = 0;
      hi   = -1;
      j    = 0;
      conv = 1'b0;
      if (!id[1]) begin
         if (f < LED_WIDTH) begin
            lo = id[0] ? f : LED_WIDTH - 1 - f;
            hi = lo;
         end
      end else if (f < LED_WIDTH / 2) begin
         conv = 1'b1;
      end else if (f < LED_WIDTH - 1) begin
         j  = f - LED_WIDTH / 2 + 1;
         lo = id[0] ? LED_WIDTH / 2 - 1 - j : LED_WIDTH / 2 - 1;
         hi = id[0] ? LED_WIDTH / 2         : LED_WIDTH / 2 + j;
      end
      for (int b = 0; b < LED_WIDTH; b++) begin
         p[b] = (b >= lo && b <= hi) || (conv && (b == f || b == LED_WIDTH - 1 - f));
      end
      return p;
   endfunction

   // Start arbitration: wins first, then the pending goal, then fresh goals.
   // Any goal not started is what remains for the pending slot.
   always_comb begin
      start_vld = 1'b1;
      start_id  = 2'd0;
      keep_vld  = 1'b0;
      keep_id   = 1'b0;
      if (win_player_1) begin
         start_id = 2'd2;
      end else if (win_player_2) begin
         start_id = 2'd3;
      end else if (pend_vld) begin
         start_id = {1'b0, pend_id};
         keep_vld = goal_player_1 | goal_player_2;
         keep_id  = ~goal_player_1;
      end else if (goal_player_1) begin
         start_id = 2'd0;
         keep_vld = goal_player_2;
         keep_id  = 1'b1;
      end else if (goal_player_2) begin
         start_id = 2'd1;
      end else begin
         start_vld = 1'b0;
      end
   end

   always_comb begin
      nxt_state    = state;
      nxt_id       = anim_id;
      nxt_lead     = lead_cnt;
      nxt_step     = step_cnt;
      nxt_frame    = frame_idx;
      nxt_rep      = rep_cnt;
      nxt_pend_vld = pend_vld;
      nxt_pend_id  = pend_id;
      nxt_done     = 1'b0;
      launch       = 1'b0;
      frame_last   = anim_id[1] ? WIN_LAST : GOAL_LAST;
      case (state)
         IDLE: launch = start_vld;
         default: begin
            if (!anim_id[1] && (win_player_1 || win_player_2)) begin
               launch = 1'b1;
            end else begin
               if (!anim_id[1] && (goal_player_1 || goal_player_2)) begin
                  nxt_pend_vld = 1'b1;
                  nxt_pend_id  = ~goal_player_1;
               end
               if (state == LEAD) begin
                  if (lead_cnt == LEAD_LAST) begin
                     nxt_state = RUN;
                     nxt_lead  = '0;
                  end else begin
                     nxt_lead = lead_cnt + 1'b1;
                  end
               end else if (step_cnt != STEP_LAST) begin
                  nxt_step = step_cnt + 1'b1;
               end else begin
                  nxt_step = '0;
                  if (frame_idx != frame_last) begin
                     nxt_frame = frame_idx + 1'b1;
                  end else begin
                     nxt_frame = '0;
                     if (rep_cnt != REP_LAST) begin
                        nxt_rep = rep_cnt + 1'b1;
                     end else begin
                        nxt_done  = 1'b1;
                        nxt_state = IDLE;
                        launch    = start_vld;
                     end
                  end
               end
            end
         end
      endcase
      if (launch) begin
         nxt_state    = (LEAD_CYCLES == 0) ? RUN : LEAD;
         nxt_id       = start_id;
         nxt_lead     = '0;
         nxt_step     = '0;
         nxt_frame    = '0;
         nxt_rep      = '0;
         nxt_pend_vld = keep_vld;
         nxt_pend_id  = keep_id;
      end
   end

   always_ff @(posedge BALL_CLOCK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         anim_id   <= 2'd0;
         lead_cnt  <= '0;
         step_cnt  <= '0;
         frame_idx <= '0;
         rep_cnt   <= '0;
         pend_vld  <= 1'b0;
         pend_id   <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         led       <= '0;
      end else begin
         state     <= nxt_state;
         anim_id   <= nxt_id;
         lead_cnt  <= nxt_lead;
         step_cnt  <= nxt_step;
         frame_idx <= nxt_frame;
         rep_cnt   <= nxt_rep;
         pend_vld  <= nxt_pend_vld;
         pend_id   <= nxt_pend_id;
         done      <= nxt_done;
         busy      <= (nxt_state != IDLE);
         led       <= (nxt_state == RUN) ? pattern(nxt_id, nxt_frame) : '0;
      end
   end

endmodule

// File: tb/tb_led_animator.sv
// Directed bench for led_animator: default 8-LED instance plus a 6-LED,
// two-cycle-step, no-lead, single-repeat instance.
module tb_led_animator;

   logic       BALL_CLOCK = 1'b0;
   logic       RESET = 1'b1;
   logic       g1 = 1'b0, g2 = 1'b0, w1 = 1'b0, w2 = 1'b0;
   logic [7:0] led;
   logic       busy, done;
   logic [1:0] anim_id;

   logic       w1_6 = 1'b0, zero6 = 1'b0;
   logic [5:0] led6;
   logic       busy6, done6;
   logic [1:0] anim6;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] tbl [4][9];
   logic [5:0] tbl6 [6];

   always #5 BALL_CLOCK = ~BALL_CLOCK;

   led_animator dut (
      .BALL_CLOCK(BALL_CLOCK), .RESET(RESET),
      .goal_player_1(g1), .goal_player_2(g2),
      .win_player_1(w1), .win_player_2(w2),
      .led(led), .busy(busy), .done(done), .anim_id(anim_id)
   );

   led_animator #(.LED_WIDTH(6), .STEP_CYCLES(2), .LEAD_CYCLES(0), .REPEATS(1)) dut6 (
      .BALL_CLOCK(BALL_CLOCK), .RESET(RESET),
      .goal_player_1(zero6), .goal_player_2(zero6),
      .win_player_1(w1_6), .win_player_2(zero6),
      .led(led6), .busy(busy6), .done(done6), .anim_id(anim6)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge BALL_CLOCK);
      #1;
   endtask

   // sel: 1=goal1 2=goal2 3=win1 4=win2; held for exactly one sampling edge
   task automatic fire(input int sel);
      g1 = (sel == 1);
      g2 = (sel == 2);
      w1 = (sel == 3);
      w2 = (sel == 4);
      tick();
      g1 = 1'b0; g2 = 1'b0; w1 = 1'b0; w2 = 1'b0;
   endtask

   function automatic logic [7:0] exp_led(input logic [1:0] id, input int c);
      if (c < 3) return 8'h00;
      return tbl[id][(c - 3) % (id[1] ? 8 : 9)];
   endfunction

   // Checks cycles c0..c1-1 after an animation start; optionally fires an event at inj_at.
   task automatic expect_frames(input string tag, input logic [1:0] id, input int c0,
                                input int c1, input int inj_at, input int inj_sel,
                                input logic first_done);
      for (int c = c0; c < c1; c++) begin
         check($sformatf("%s_led_c%0d", tag, c), 32'(led), 32'(exp_led(id, c)));
         check($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'd1);
         check($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'((c == 0) && first_done));
         check($sformatf("%s_id_c%0d", tag, c), 32'(anim_id), 32'(id));
         if (c == inj_at) fire(inj_sel);
         else tick();
      end
   endtask

   task automatic expect_end(input string tag, input logic [1:0] id);
      check({tag, "_end_busy"}, 32'(busy), 32'd0);
      check({tag, "_end_done"}, 32'(done), 32'd1);
      check({tag, "_end_led"}, 32'(led), 32'd0);
      check({tag, "_end_id"}, 32'(anim_id), 32'(id));
      tick();
      check({tag, "_post_done"}, 32'(done), 32'd0);
      check({tag, "_post_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      tbl[0] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
      tbl[1] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
      tbl[2] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h38, 8'h78, 8'hF8, 8'h00, 8'h00};
      tbl[3] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h1C, 8'h1E, 8'h1F, 8'h00, 8'h00};
      tbl6   = '{6'h21, 6'h12, 6'h0C, 6'h1C, 6'h3C, 6'h00};

      tick();
      tick();
      check("rst_led", 32'(led), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_id", 32'(anim_id), 32'd0);
      check("rst_busy6", 32'(busy6), 32'd0);
      RESET = 1'b0;
      tick();

      // GOAL1 alone
      fire(1);
      expect_frames("g1", 2'd0, 0, 30, -1, 0, 1'b0);
      expect_end("g1", 2'd0);

      // WIN2 alone
      fire(4);
      expect_frames("w2", 2'd3, 0, 27, -1, 0, 1'b0);
      expect_end("w2", 2'd3);

      // GOAL2 queued during GOAL1 chains with no busy gap
      fire(1);
      expect_frames("chain_g1", 2'd0, 0, 30, 9, 2, 1'b0);
      expect_frames("chain_g2", 2'd1, 0, 30, -1, 0, 1'b1);
      expect_end("chain_g2", 2'd1);

      // WIN1 preempts GOAL2 with a goal pending; pending is discarded
      fire(2);
      expect_frames("pre_g2", 2'd1, 0, 4, 3, 1, 1'b0);
      expect_frames("pre_g2", 2'd1, 4, 8, 7, 3, 1'b0);
      expect_frames("pre_w1", 2'd2, 0, 27, -1, 0, 1'b0);
      expect_end("pre_w1", 2'd2);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("pend_gone_busy_%0d", i), 32'(busy), 32'd0);
         tick();
      end

      // Asynchronous reset in the middle of RUN
      fire(2);
      expect_frames("rst_g2", 2'd1, 0, 8, -1, 0, 1'b0);
      RESET = 1'b1;
      #1;
      check("mid_rst_led", 32'(led), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_id", 32'(anim_id), 32'd0);
      tick();
      tick();
      RESET = 1'b0;
      tick();
      check("post_rst_busy", 32'(busy), 32'd0);
      fire(1);
      expect_frames("rst_g1", 2'd0, 0, 30, -1, 0, 1'b0);
      expect_end("rst_g1", 2'd0);

      // 6-LED, 2-cycle frames, no lead-in, one repeat
      w1_6 = 1'b1;
      tick();
      w1_6 = 1'b0;
      for (int c = 0; c < 12; c++) begin
         check($sformatf("w6_led_c%0d", c), 32'(led6), 32'(tbl6[c / 2]));
         check($sformatf("w6_busy_c%0d", c), 32'(busy6), 32'd1);
         check($sformatf("w6_done_c%0d", c), 32'(done6), 32'd0);
         check($sformatf("w6_id_c%0d", c), 32'(anim6), 32'd2);
         tick();
      end
      check("w6_end_busy", 32'(busy6), 32'd0);
      check("w6_end_done", 32'(done6), 32'd1);
      check("w6_end_led", 32'(led6), 32'd0);
      tick();
      check("w6_post_done", 32'(done6), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
